// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer.
// Drives the screen code on `state` and owns the session variables: hearts,
// key/door lock, the invulnerability window and the stage-clear timer.
// One frame counter serves two purposes. It is the invulnerability timer
// inside a stage, and the hold timer on a SUCCESSn screen.
// Optional feature: define GAME_PAUSE_EN to add btn_pause / paused.
module game_flow_ctrl #(
    parameter int HEARTS         = 3,
    parameter int SUCCESS_FRAMES = 120,
    parameter int INVULN_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_staff,
    input  logic       key_pick,
    input  logic       at_door,
    input  logic       player_hit,
    input  logic       boss_dead,
`ifdef GAME_PAUSE_EN
    input  logic       btn_pause,
    output logic       paused,
`endif
    output logic [3:0] state,
    output logic [2:0] heart,
    output logic       key_find,
    output logic       isLocked,
    output logic       invuln
);

    localparam int CNT_MAX = (SUCCESS_FRAMES > INVULN_FRAMES) ? SUCCESS_FRAMES : INVULN_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_TITLE    = 4'd0,
        S_STAFF    = 4'd1,
        S_STAGE1   = 4'd2,
        S_SUCCESS1 = 4'd3,
        S_STAGE2   = 4'd4,
        S_SUCCESS2 = 4'd5,
        S_STAGE3   = 4'd6,
        S_SUCCESS3 = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [2:0]       heart_q, heart_nx;
    logic             key_q, key_nx;
    logic             inv_q, inv_nx;
    logic             pause_q, pause_nx;
    logic             pause_btn;

    logic in_stage, nx_stage, nx_success;
    logic tick, hit_ok, fatal, door_ok, cnt_last;

`ifdef GAME_PAUSE_EN
    assign pause_btn = btn_pause;
    assign paused    = pause_q;
`else
    assign pause_btn = 1'b0;
`endif

    assign in_stage   = (state_q == S_STAGE1) || (state_q == S_STAGE2) || (state_q == S_STAGE3);
    assign nx_stage   = (state_nx == S_STAGE1) || (state_nx == S_STAGE2) || (state_nx == S_STAGE3);
    assign nx_success = (state_nx == S_SUCCESS1) || (state_nx == S_SUCCESS2) || (state_nx == S_SUCCESS3);

    // While paused, gameplay events and frame ticks are masked out.
    assign tick     = frame_tick & ~pause_q;
    assign hit_ok   = in_stage & player_hit & ~inv_q & ~pause_q & (heart_q != 3'd0);
    assign fatal    = hit_ok & (heart_q == 3'd1);
    assign door_ok  = key_q & at_door & ~pause_q;
    assign cnt_last = (cnt_q <= CNT_W'(1));

    // State and session registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_TITLE;
            cnt_q   <= '0;
            heart_q <= 3'(HEARTS);
            key_q   <= 1'b0;
            inv_q   <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            heart_q <= heart_nx;
            key_q   <= key_nx;
            inv_q   <= inv_nx;
            pause_q <= pause_nx;
        end
    end

    // Next-state logic. A fatal hit takes priority over stage completion.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_TITLE:    if (btn_start) state_nx = S_STAGE1;
                        else if (btn_staff) state_nx = S_STAFF;
            S_STAFF:    if (btn_start || btn_staff) state_nx = S_TITLE;
            S_STAGE1:   if (fatal) state_nx = S_FAIL;
                        else if (door_ok) state_nx = S_SUCCESS1;
            S_STAGE2:   if (fatal) state_nx = S_FAIL;
                        else if (door_ok) state_nx = S_SUCCESS2;
            S_STAGE3:   if (fatal) state_nx = S_FAIL;
                        else if (boss_dead && !pause_q) state_nx = S_SUCCESS3;
            S_SUCCESS1: if (tick && cnt_last) state_nx = S_STAGE2;
            S_SUCCESS2: if (tick && cnt_last) state_nx = S_STAGE3;
            S_SUCCESS3: if (tick && cnt_last) state_nx = S_TITLE;
            S_FAIL:     if (btn_start) state_nx = S_TITLE;
            default:    state_nx = S_TITLE;
        endcase
    end

    // Next values of the session registers (hearts, key, timers, pause).
    always_comb begin
        cnt_nx   = cnt_q;
        heart_nx = heart_q;
        key_nx   = key_q;
        inv_nx   = inv_q;
        pause_nx = pause_q;

        if (in_stage) begin
            if (inv_q && tick) begin
                cnt_nx = cnt_last ? '0 : cnt_q - CNT_W'(1);
                if (cnt_last) inv_nx = 1'b0;
            end
            if (key_pick && !pause_q && (state_q != S_STAGE3)) key_nx = 1'b1;
            if (hit_ok) begin
                heart_nx = heart_q - 3'd1;
                if (INVULN_FRAMES != 0) begin
                    inv_nx = 1'b1;
                    cnt_nx = CNT_W'(INVULN_FRAMES);
                end
            end
            if (pause_btn) pause_nx = ~pause_q;
        end else if (state_q == S_SUCCESS1 || state_q == S_SUCCESS2 || state_q == S_SUCCESS3) begin
            if (tick) cnt_nx = cnt_last ? '0 : cnt_q - CNT_W'(1);
        end

        if ((state_q == S_TITLE || state_q == S_FAIL) && btn_start) heart_nx = 3'(HEARTS);

        // Entry and leave clean-up is applied after the per-state updates so
        // that it overrides them on the transition edge.
        if (!nx_stage) begin
            key_nx   = 1'b0;
            inv_nx   = 1'b0;
            pause_nx = 1'b0;
        end
        if (state_nx != state_q) begin
            if (nx_success) cnt_nx = CNT_W'(SUCCESS_FRAMES);
            if (nx_stage) begin
                key_nx   = 1'b0;
                inv_nx   = 1'b0;
                pause_nx = 1'b0;
                cnt_nx   = '0;
            end
        end
    end

    assign state    = state_q;
    assign heart    = heart_q;
    assign key_find = key_q;
    assign isLocked = ~key_q;
    assign invuln   = inv_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl
// (HEARTS=3, SUCCESS_FRAMES=4, INVULN_FRAMES=2).
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0, btn_start = 1'b0, btn_staff = 1'b0;
    logic       key_pick = 1'b0, at_door = 1'b0, player_hit = 1'b0, boss_dead = 1'b0;
    logic [3:0] state;
    logic [2:0] heart;
    logic       key_find, isLocked, invuln;
`ifdef GAME_PAUSE_EN
    logic       btn_pause = 1'b0;
    logic       paused;
`endif

    int checks = 0;
    int errors = 0;

    game_flow_ctrl #(
        .HEARTS(3),
        .SUCCESS_FRAMES(4),
        .INVULN_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .btn_start(btn_start),
        .btn_staff(btn_staff),
        .key_pick(key_pick),
        .at_door(at_door),
        .player_hit(player_hit),
        .boss_dead(boss_dead),
`ifdef GAME_PAUSE_EN
        .btn_pause(btn_pause),
        .paused(paused),
`endif
        .state(state),
        .heart(heart),
        .key_find(key_find),
        .isLocked(isLocked),
        .invuln(invuln)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_state", state, 0);
        chk("rst_heart", heart, 3);
        chk("rst_key", key_find, 0);
        chk("rst_lock", isLocked, 1);
        chk("rst_inv", invuln, 0);
        rst = 1'b1;
        step();
        chk("idle_title", state, 0);

        // Start game
        btn_start = 1'b1; step(); btn_start = 1'b0;
        chk("start_stage1", state, 2);
        chk("start_heart", heart, 3);
        chk("start_lock", isLocked, 1);

        // STAGE1: key then door
        key_pick = 1'b1; step(); key_pick = 1'b0;
        chk("key_find", key_find, 1);
        chk("key_unlock", isLocked, 0);
        chk("key_stay", state, 2);
        at_door = 1'b1; step(); at_door = 1'b0;
        chk("door_succ1", state, 3);
        chk("succ1_key", key_find, 0);
        chk("succ1_lock", isLocked, 1);

        // Buttons ignored in SUCCESS, 4 ticks to advance
        btn_start = 1'b1; btn_staff = 1'b1; step(); btn_start = 1'b0; btn_staff = 1'b0;
        chk("succ_btn_ignored", state, 3);
        ticks(3);
        chk("succ1_hold3", state, 3);
        ticks(1);
        chk("succ1_to_stage2", state, 4);
        chk("stage2_heart", heart, 3);

        // Key and door in same cycle: no completion
        key_pick = 1'b1; at_door = 1'b1; step(); key_pick = 1'b0; at_door = 1'b0;
        chk("same_cycle_door", state, 4);
        chk("same_cycle_key", key_find, 1);

        // Damage and invulnerability
        player_hit = 1'b1; step(); player_hit = 1'b0;
        chk("hit1_heart", heart, 2);
        chk("hit1_inv", invuln, 1);
        ticks(1);
        player_hit = 1'b1; step(); player_hit = 1'b0;
        chk("hit_ignored", heart, 2);
        ticks(1);
        chk("inv_cleared", invuln, 0);
        ticks(1);
        player_hit = 1'b1; step(); player_hit = 1'b0;
        chk("hit2_heart", heart, 1);
        ticks(3);
        chk("inv2_cleared", invuln, 0);

        // Fatal hit beats door completion
        player_hit = 1'b1; at_door = 1'b1; step(); player_hit = 1'b0; at_door = 1'b0;
        chk("fatal_state", state, 8);
        chk("fatal_heart", heart, 0);

        // FAIL -> TITLE
        btn_start = 1'b1; step(); btn_start = 1'b0;
        chk("fail_title", state, 0);
        chk("fail_heart", heart, 3);
        chk("fail_key", key_find, 0);

        // Run through to STAGE3
        btn_start = 1'b1; step(); btn_start = 1'b0;
        key_pick = 1'b1; step(); key_pick = 1'b0;
        at_door = 1'b1; step(); at_door = 1'b0;
        ticks(4);
        key_pick = 1'b1; step(); key_pick = 1'b0;
        at_door = 1'b1; step(); at_door = 1'b0;
        chk("reach_succ2", state, 5);
        ticks(4);
        chk("reach_stage3", state, 6);
        chk("stage3_lock", isLocked, 1);
        boss_dead = 1'b1; step(); boss_dead = 1'b0;
        chk("boss_succ3", state, 7);
        ticks(3);
        chk("succ3_hold", state, 7);
        ticks(1);
        chk("succ3_title", state, 0);
        chk("carry_heart", heart, 3);

        // STAFF screen
        btn_staff = 1'b1; step(); btn_staff = 1'b0;
        chk("staff", state, 1);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        chk("staff_back", state, 0);

        // start has priority over staff
        btn_start = 1'b1; btn_staff = 1'b1; step(); btn_start = 1'b0; btn_staff = 1'b0;
        chk("start_priority", state, 2);

`ifdef GAME_PAUSE_EN
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
        chk("paused_on", paused, 1);
        ticks(10);
        player_hit = 1'b1; step(); player_hit = 1'b0;
        chk("paused_heart", heart, 3);
        chk("paused_state", state, 2);
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
        chk("paused_off", paused, 0);
`endif

        // Reach STAGE2 with heart=1, key_find=1, then async reset
        key_pick = 1'b1; step(); key_pick = 1'b0;
        at_door = 1'b1; step(); at_door = 1'b0;
        ticks(4);
        key_pick = 1'b1; step(); key_pick = 1'b0;
        player_hit = 1'b1; step(); player_hit = 1'b0;
        ticks(3);
        player_hit = 1'b1; step(); player_hit = 1'b0;
        chk("pre_rst_state", state, 4);
        chk("pre_rst_heart", heart, 1);
        chk("pre_rst_key", key_find, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_heart", heart, 3);
        chk("async_key", key_find, 0);
        chk("async_lock", isLocked, 1);
        chk("async_inv", invuln, 0);
        #10;
        rst = 1'b1;
        step();
        chk("post_rst_title", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer that drives the 4-bit `state` bus consumed by the display path and sprite drawers.
- Owns the session variables shown by the interface layer: hearts remaining, key found, door lock, stage-clear timer.
- Converts single-cycle gameplay event pulses and a per-frame tick into screen and stage transitions.
- Sits between input and collision logic upstream and game_display downstream.

Parameters:
- HEARTS, 3: hearts loaded at each new game; range 1..7.
- SUCCESS_FRAMES, 120: frames a SUCCESSn screen is held before auto-advance; at least 1.
- INVULN_FRAMES, 60: frames after a hit during which further hits are ignored; 0 disables.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse once per video frame.
- btn_start  in  1  one-cycle pulse: start or confirm.
- btn_staff  in  1  one-cycle pulse: open the staff screen from TITLE.
- key_pick  in  1  pulse: player touched the key.
- at_door  in  1  level: player overlaps the door.
- player_hit  in  1  pulse: player took damage.
- boss_dead  in  1  pulse: boss defeated.
- state  out  4  screen code: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
- heart  out  3  hearts remaining.
- key_find  out  1  key collected in the current stage.
- isLocked  out  1  door locked; always equal to ~key_find (registered together).
- invuln  out  1  invulnerability window active.

Behaviour:
- All outputs are registered.
- Reset values: state=TITLE, heart=HEARTS, key_find=0, isLocked=1, invuln=0; internal frame counter=0.
- Events sampled on a clk edge take effect on the following edge, so latency is 1 cycle.
- TITLE:
  - btn_start goes to STAGE1 and loads heart=HEARTS.
  - else btn_staff goes to STAFF.
  - btn_start has priority over btn_staff.
- STAFF: btn_start or btn_staff returns to TITLE.
- STAGE1 and STAGE2:
  - key_pick sets key_find=1 and isLocked=0.
  - If key_find=1 and at_door=1 in the same cycle, go to SUCCESS1 or SUCCESS2.
  - key_pick in the same cycle as at_door does not complete the stage; completion is checked against the key_find value registered before that edge.
- STAGE3: boss_dead goes to SUCCESS3. key_find and door are not used in this stage.
- Damage, any STAGEn:
  - player_hit with invuln=0 decrements heart, sets invuln=1 and loads the frame counter with INVULN_FRAMES.
  - If heart=1 when the hit lands, heart becomes 0 and the next state is FAIL.
  - FAIL has priority over stage completion in the same cycle.
  - player_hit with invuln=1 is ignored.
  - heart never underflows.
- Invulnerability timer: decrements on frame_tick while invuln=1; invuln clears on the tick where the counter reaches 0. With INVULN_FRAMES=0, invuln never asserts.
- SUCCESSn:
  - On entry, counter=SUCCESS_FRAMES, key_find=0 and isLocked=1.
  - Counter decrements on frame_tick; at 0 go to STAGE(n+1), or TITLE after SUCCESS3.
  - heart is carried over to the next stage.
  - Button presses are ignored during SUCCESSn.
- FAIL: btn_start goes to TITLE with heart=HEARTS and key_find=0.
- On every entry to a STAGEn, key_find=0, isLocked=1, invuln=0.
- Encodings 9..15: next state is TITLE (recovery). Not reachable in normal operation.
- Reset asserted mid-game returns to the reset values immediately, without waiting for a clk edge.
- The frame counter is wide enough for max(SUCCESS_FRAMES, INVULN_FRAMES) and never wraps.

Optional Feature:
- Macro GAME_PAUSE_EN.
  - Defined: adds input btn_pause (one-cycle pulse) and output paused.
  - In STAGEn, btn_pause toggles paused.
  - While paused: frame_tick, key_pick, player_hit and boss_dead are ignored, at_door completion is blocked, and state is held.
  - paused is cleared on reset and on leaving a STAGEn.
  - In non-stage states, btn_pause is ignored and paused=0.
- Undefined: no btn_pause or paused ports; behaviour as above.

Test Plan (HEARTS=3, SUCCESS_FRAMES=4, INVULN_FRAMES=2 unless stated):
- Reset release, then btn_start -> state 0 then 2 one cycle later; heart=3; isLocked=1.
- STAGE1: key_pick, then at_door=1 -> key_find=1 and isLocked=0; next cycle state=3; after 4 frame_ticks state=4; heart still 3.
- STAGE2: three player_hit pulses spaced 3 frame_ticks apart -> heart 2, 1, 0; state=8 after the third hit. A hit one frame after the first is ignored (heart stays 2).
- Same-cycle player_hit with heart=1 and at_door with key_find=1 -> state=8, not 5.
- STAGE3: boss_dead -> state=7; after 4 frame_ticks state=0. btn_staff -> 1; btn_start -> 0.
- Reset pulsed low mid-STAGE2 with heart=1, key_find=1 -> outputs return to state=0, heart=3, key_find=0 without a clk edge. With GAME_PAUSE_EN: pause in STAGE1, then 10 frame_ticks plus player_hit -> heart unchanged.
